fb_arbiter: RTL
===============

# fb_arbiter

Single-port frame-buffer access arbiter between the VGA scanout path and the SPI pixel-write path. Scanout reads have absolute priority so video timing never slips. SPI writes are buffered in a small FIFO and drained into the RAM on any cycle where scanout does not need it, typically blanking or idle slots. Sits in `top` between the SPI receiver, the VGA pixel pipeline and the frame-buffer block RAM, all on the HSOSC-derived `clk`.

## Interface
- `ADDR_W`, 15: frame-buffer address width (160×120 pixels = 19200 words).
- `DATA_W`, 8: pixel width.
- `FIFO_DEPTH`, 4: write-FIFO entries; must be a power of two, ≥2.
- `STARVE_LIM`, 64: consecutive blocked cycles before `starve` sets.

Ports (name, direction, width, meaning):
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `vid_req` in 1: scanout requests a read this cycle.
- `vid_addr` in ADDR_W: read address.
- `vid_data` out DATA_W: registered read pixel.
- `vid_valid` out 1: `vid_data` is valid this cycle.
- `wr_valid` in 1: SPI side offers a write.
- `wr_ready` out 1: FIFO can accept the offered write.
- `wr_addr` in ADDR_W: write address.
- `wr_data` in DATA_W: write pixel.
- `wr_count` out $clog2(FIFO_DEPTH)+1: FIFO occupancy.
- `ram_en` out 1: RAM access enable.
- `ram_we` out 1: RAM write enable.
- `ram_addr` out ADDR_W: RAM address.
- `ram_wdata` out DATA_W: RAM write data.
- `ram_rdata` in DATA_W: RAM read data, one-cycle synchronous latency.
- `starve` out 1: sticky write-starvation error flag.

## Operation
- **Reset values.** `vid_data`=0, `vid_valid`=0, `wr_count`=0, `starve`=0. The FIFO is emptied and the starve counter is 0. `wr_ready`=1 during and after reset.
- **Write acceptance.** A write is accepted on an edge where `wr_valid && wr_ready`. `wr_ready` = `wr_count < FIFO_DEPTH`, computed from registered count only. A simultaneous pop in the same cycle does not raise `wr_ready`.
- **Grant, decided combinationally each cycle.**
  - If `vid_req`: `ram_en`=1, `ram_we`=0, `ram_addr`=`vid_addr`.
  - Else if the FIFO is non-empty: `ram_en`=1, `ram_we`=1, `ram_addr`/`ram_wdata` come from the FIFO head, and the head is popped at the cycle end.
  - Else: `ram_en`=0, `ram_we`=0, `ram_addr`/`ram_wdata`=0.
- **No FIFO bypass.** A write accepted in cycle N reaches the RAM at the earliest in cycle N+1.
- **Simultaneous push and pop.** Both happen; `wr_count` is unchanged.
- **Read-after-write hazard.** Not resolved. A scanout read of an address with a pending FIFO write returns the old RAM contents; a tear of at most one frame is accepted.
- **Write ordering.** Writes reach RAM strictly in acceptance order. A repeated address means last write wins.
- **Starvation counter.**
  - Increments each cycle that the FIFO is non-empty and `vid_req`=1.
  - Clears on any pop.
  - Saturates at `STARVE_LIM`.
  - Reaching `STARVE_LIM` sets `starve`, which holds until `reset`.
- **Pointer arithmetic.** FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. Full/empty is derived from the count.

## Timing
- **Read latency.** `vid_req` in cycle N gives `ram_rdata` valid in N+1. `vid_data` is registered at the end of N+1 and `vid_valid`=1 in cycle N+2. Fully pipelined: one read per cycle, back-to-back.
- **`vid_valid` with no request.** `vid_valid`=0 in cycle N+2 if `vid_req`=0 in N. `vid_data` holds its last value.
- **Write latency.** Accepted write to RAM write takes ≥1 cycle, unbounded while `vid_req` is held.
- **Reset asserted mid-operation.** Pending FIFO writes are discarded and never reach the RAM. An in-flight read does not produce `vid_valid`.

## Structure
- **Shared package `fb_pkg`.** Holds `FB_ADDR_W`=15, `FB_DATA_W`=8, and `typedef struct packed {addr; data} fb_wr_t`. Also used by the SPI receiver and VGA pipeline.
- **Sub-module `fb_wr_fifo`.** Synchronous FIFO of `fb_wr_t`, parameterised by depth. Provides push, pop, head, count, full and empty.
- **Arbiter top.** Holds the grant mux, the read-valid pipeline and the starvation counter.

## Test plan
1. **Reset.** Pulse `reset` asynchronously mid-cycle → outputs as listed under reset values immediately, and `wr_ready`=1.
2. **Scanout read.** `vid_req`=1, `vid_addr`=0x0010 in cycle N; model RAM returns 0xA5 in N+1 → `ram_en`=1/`ram_we`=0/`ram_addr`=0x0010 in N; `vid_data`=0xA5 and `vid_valid`=1 in N+2. Back-to-back addresses 0x0010–0x0013 give four consecutive valid cycles.
3. **Idle write.** Push (0x0123, 0x3C) with `vid_req`=0 → the next cycle shows `ram_we`=1, `ram_addr`=0x0123, `ram_wdata`=0x3C, and `wr_count` returns to 0 after it.
4. **Contention.** Hold `vid_req`=1 for 10 cycles and offer 5 writes.
   - Exactly 4 are accepted; `wr_ready`=0 after the 4th; `ram_we` stays 0 throughout.
   - Release `vid_req` → 4 writes in 4 consecutive cycles in acceptance order; the 5th is accepted once a slot frees.
5. **Starvation.** With `STARVE_LIM`=8, keep one FIFO entry pending and `vid_req`=1 for 8 cycles → `starve`=1. Drain the FIFO → `starve` stays 1 until `reset`. With 7 cycles only → `starve` stays 0.
6. **Reset mid-operation.** Queue 3 writes under `vid_req`=1, assert `reset`, then release with `vid_req`=0 → `wr_count`=0 and no `ram_we` pulses ever occur.

Source files
------------

// File: rtl/fb_pkg.sv
// fb_pkg: definitions shared by the frame-buffer arbiter, the SPI pixel
// receiver and the VGA scanout pipeline.
//   FB_ADDR_W / FB_DATA_W : frame-buffer address and pixel widths
//   fb_wr_t               : one buffered pixel write (address + data)
//   fb_cnt_w()            : occupancy-counter width for a FIFO of a given depth
package fb_pkg;

  localparam int FB_ADDR_W = 15;  // 160x120 = 19200 words
  localparam int FB_DATA_W = 8;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [FB_DATA_W-1:0] data;
  } fb_wr_t;

  // An occupancy counter must represent 0..depth inclusive.
  function automatic int fb_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fb_arbiter_if.sv
// fb_arbiter_if: bundles the scanout read port, the SPI write port and the
// frame-buffer RAM port of fb_arbiter.
//   vid_req/vid_addr -> vid_data/vid_valid   : scanout reads (fixed latency)
//   wr_valid/wr_ready/wr_addr/wr_data         : SPI write handshake
//   wr_count                                  : write-FIFO occupancy
//   ram_en/ram_we/ram_addr/ram_wdata/ram_rdata: single-port RAM
//   starve                                    : sticky write-starvation flag
//
// Handshake: a write transfers on a rising clk edge where wr_valid and
// wr_ready are both high. wr_ready depends only on registered state, never
// on wr_valid. While wr_valid is high and wr_ready low the master keeps
// wr_addr/wr_data stable. vid_req has no back-pressure: every request is
// answered with vid_valid exactly two cycles later.
//
// Modports: slave = arbiter side, master = environment (SPI/VGA/RAM).
interface fb_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 3
);
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic [DATA_W-1:0] vid_data;
  logic              vid_valid;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [CNT_W-1:0]  wr_count;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic              starve;

  modport slave (
    input  vid_req, vid_addr, wr_valid, wr_addr, wr_data, ram_rdata,
    output vid_data, vid_valid, wr_ready, wr_count,
           ram_en, ram_we, ram_addr, ram_wdata, starve
  );

  modport master (
    output vid_req, vid_addr, wr_valid, wr_addr, wr_data, ram_rdata,
    input  vid_data, vid_valid, wr_ready, wr_count,
           ram_en, ram_we, ram_addr, ram_wdata, starve
  );

endinterface

// File: rtl/fb_wr_fifo.sv
// fb_wr_fifo: synchronous FIFO of fb_wr_t entries.
//   clk, reset      : clock, asynchronous active-high reset (empties FIFO)
//   push, push_data : enqueue (ignored while full)
//   pop             : dequeue the head (ignored while empty)
//   head            : current head entry (valid while !empty)
//   count           : occupancy 0..DEPTH
//   full, empty     : derived from count
// Pointers are $clog2(DEPTH) bits and wrap naturally, so DEPTH must be a
// power of two. The storage array itself is not reset; count gates it.
module fb_wr_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = fb_cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  fb_wr_t           push_data,
  input  logic             pop,
  output fb_wr_t           head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  fb_wr_t           mem_q [DEPTH];
  fb_wr_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage: no reset needed, entries are only read below count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fb_arbiter.sv
// fb_arbiter: single-port frame-buffer arbiter. Scanout reads always win
// the RAM; SPI writes queue in fb_wr_fifo and drain on cycles without a
// scanout request.
//   clk, reset : system clock, asynchronous active-high reset
//   bus        : fb_arbiter_if.slave (scanout port, SPI write port,
//                RAM port, wr_count, starve)
// Parameters: ADDR_W/DATA_W must equal FB_ADDR_W/FB_DATA_W of fb_pkg,
// FIFO_DEPTH is a power of two >= 2, STARVE_LIM is the number of
// consecutive blocked cycles that raises the sticky starve flag.
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W     = FB_ADDR_W,
  parameter int DATA_W     = FB_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_LIM = 64,
  localparam int CNT_W     = fb_cnt_w(FIFO_DEPTH),
  localparam int SCNT_W    = $clog2(STARVE_LIM + 1)
) (
  input  logic        clk,
  input  logic        reset,
  fb_arbiter_if.slave bus
);

  fb_wr_t           push_data;
  fb_wr_t           fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  logic              rd_pend_q, rd_pend_d;
  logic              vid_valid_q, vid_valid_d;
  logic [DATA_W-1:0] vid_data_q, vid_data_d;
  logic [SCNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic              starve_q, starve_d;

  // wr_ready comes from the registered count only, so a pop in the same
  // cycle does not open a slot until the next cycle.
  assign bus.wr_ready = !fifo_full;
  assign push         = bus.wr_valid && !fifo_full;
  assign push_data    = '{addr: bus.wr_addr, data: bus.wr_data};

  // The FIFO drains only on cycles scanout leaves the RAM free. A write
  // pushed this cycle is not visible at the head until the next cycle.
  assign pop = !bus.vid_req && !fifo_empty;

  fb_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.wr_count = fifo_count;

  // RAM grant: scanout read, else FIFO head write, else idle.
  always_comb begin
    bus.ram_en    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    if (bus.vid_req) begin
      bus.ram_en   = 1'b1;
      bus.ram_addr = bus.vid_addr;
    end else if (!fifo_empty) begin
      bus.ram_en    = 1'b1;
      bus.ram_we    = 1'b1;
      bus.ram_addr  = fifo_head.addr;
      bus.ram_wdata = fifo_head.data;
    end
  end

  // Read pipeline: request in N, RAM data in N+1, vid_data/vid_valid in N+2.
  // vid_data keeps its last value on cycles without a returning read.
  always_comb begin
    rd_pend_d   = bus.vid_req;
    vid_valid_d = rd_pend_q;
    vid_data_d  = rd_pend_q ? bus.ram_rdata : vid_data_q;
  end

  // Starvation: count cycles where a write waits behind a scanout read,
  // clear on every drained write, saturate at the limit. The flag is sticky
  // until reset so software can see that a write was ever held that long.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (pop) begin
      starve_cnt_d = '0;
    end else if (!fifo_empty && bus.vid_req &&
                 (starve_cnt_q != SCNT_W'(STARVE_LIM))) begin
      starve_cnt_d = starve_cnt_q + SCNT_W'(1);
    end
    starve_d = starve_q || (starve_cnt_d == SCNT_W'(STARVE_LIM));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend_q    <= 1'b0;
      vid_valid_q  <= 1'b0;
      vid_data_q   <= '0;
      starve_cnt_q <= '0;
      starve_q     <= 1'b0;
    end else begin
      rd_pend_q    <= rd_pend_d;
      vid_valid_q  <= vid_valid_d;
      vid_data_q   <= vid_data_d;
      starve_cnt_q <= starve_cnt_d;
      starve_q     <= starve_d;
    end
  end

  assign bus.vid_valid = vid_valid_q;
  assign bus.vid_data  = vid_data_q;
  assign bus.starve    = starve_q;

endmodule
